coherence_bus_ctrl: RTL and testbench
=====================================

Name: coherence_bus_ctrl

Overview:
- Memory-side responder for the per-core dcache snooping-coherence interface in a dual-core system.
- Arbitrates coherence transactions (read miss, write upgrade) from two dcaches and snoops the other cache.
- Sequences snoop write-backs of dirty blocks, grants the requester, and passes block reads and plain write-backs through to a single-port RAM.
- Blocks are two 32-bit words (offset bit 2).

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, word width.
- RR_INIT, 0, core given priority after reset.

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, asynchronous, active-low
- cctrans  input  2  per-core coherence request / snoop acknowledge
- ccwrite  input  2  per-core write intent (request) / dirty (snoop response)
- dREN  input  2  per-core read request
- dWEN  input  2  per-core write request
- daddr  input  2xADDR_W  per-core word address
- dstore  input  2xDATA_W  per-core write data
- ccwait  output  2  snoop strobe to core; also tells a requesting core to back off
- ccinv  output  2  to snooped core: invalidate; to requester with ccwait=0: grant
- ccsnoopaddr  output  2xADDR_W  snoop address per core
- dwait  output  2  per-core memory wait; 0 means the access completes this cycle
- dload  output  2xDATA_W  per-core read data
- ram_ren  output  1  RAM read
- ram_wen  output  1  RAM write
- ram_addr  output  ADDR_W  RAM address
- ram_store  output  DATA_W  RAM write data
- ram_load  input  DATA_W  RAM read data
- ram_wait  input  1  RAM busy; 0 means the access completes this cycle

Behaviour:
- Reset: state IDLE, rr=RR_INIT, word counter 0. Outputs: ccwait=0, ccinv=0, ccsnoopaddr=0, dwait=2'b11, dload=0, ram_ren=0, ram_wen=0, ram_addr=0, ram_store=0.
- Reset asserted mid-transaction aborts the transaction to IDLE immediately.
- Unserved cores always see dwait=1 and dload=0.
- State, latched requester r, snoopee s=~r, address A, inv and ren flags are registered.
- ccwait, ccinv and ccsnoopaddr are decoded from the registered state.
- dwait, dload and the RAM strobes are combinational pass-through for the served core.
- A "word done" is the cycle the served strobe is high and ram_wait=0. The counter clears on every state entry.
- IDLE:
  - Plain write-back (dWEN=1, cctrans=0) has priority over coherence requests. Go to WB with w = that core; on tie, w=rr.
  - Else, if any cctrans=1 with dREN or ccwrite: pick r (on tie, r=rr), latch A=daddr[r], inv=ccwrite[r], ren=dREN[r]. Go to SNOOP.
  - No response to the request in the IDLE cycle. Snoop is visible from the next cycle.
- SNOOP:
  - Drive ccwait[s]=1, ccsnoopaddr[s]=A, ccinv[s]=inv. Drive ccwait[r]=0, ccinv[r]=0.
  - If core s drives dWEN=1 with cctrans=0, pass it to RAM (dwait[s]=ram_wait) and keep ccwait high.
  - On cctrans[s]=1 (ack): if ccwrite[s]=1 go to SWB, else go to GRANT.
- SWB:
  - ccwait[s]=0. Pass core s dWEN: ram_wen, ram_addr=daddr[s], ram_store=dstore[s], dwait[s]=ram_wait.
  - After the 2nd word done, go to GRANT.
- GRANT:
  - ccinv[r]=1, ccwait[r]=0.
  - If ren: pass core r dREN to RAM (dwait[r]=ram_wait, dload[r]=ram_load). After the 2nd word done, go to IDLE.
  - If ~ren (upgrade): hold for exactly one cycle, no RAM access, then IDLE.
  - On exit, rr <= s.
- WB:
  - Pass core w dWEN to RAM. After the 2nd word done, go to IDLE. rr is unchanged.
  - If core w drops dWEN before the 2nd word, return to IDLE.
- Only one RAM strobe is active per cycle. ram_ren and ram_wen are never both 1.
- A core's cctrans asserted while it is being snooped is its ack, never a new request.

Optional Feature:
- CC_FWD_EN defined:
  - In SWB, latch dstore[s] into a 2-word buffer indexed by daddr[s][2].
  - In GRANT after a dirty snoop with ren: serve core r from the buffer. dwait[r]=0 whenever dREN[r]=1, dload[r]=buf[daddr[r][2]], ram_ren=0.
  - Two served reads end GRANT.
- CC_FWD_EN undefined: GRANT always reads RAM.

Test Plan:
- Core0 dREN+cctrans at A=0x40, core1 acks with ccwrite=0 -> ccwait[1]=1, ccsnoopaddr[1]=0x40, ccinv[1]=0. Then ccinv[0]=1 and RAM reads 0x40, 0x44 with ram_wait=1 for 2 cycles each; dload[0] returns ram_load; end in IDLE; rr=1.
- Core1 cctrans+ccwrite at 0x80 (upgrade), core0 acks -> ccinv[0]=1 and ccwait[0]=1 during snoop; ccinv[1]=1, ccwait[1]=0 for exactly 1 cycle; ram_ren and ram_wen stay 0.
- Core0 read 0x100, core1 acks ccwrite=1 and writes 0x100=DEADBEEF, 0x104=CAFEF00D -> two ram_wen words, then core0 reads the same values. With CC_FWD_EN: dwait[0]=0 and ram_ren=0 throughout GRANT.
- After reset (RR_INIT=0), both cores assert cctrans the same cycle -> core0 wins, ccwait[1]=1. Repeat the same stimulus -> core1 wins.
- Core0 dWEN without cctrans while core1 cctrans is pending -> WB passes 2 writes first, core1 dwait=1 meanwhile; then core1 is snooped/granted.
- Reset mid-GRANT -> all outputs at reset values the same cycle; a fresh read completes normally afterwards.

Source files
------------

// File: rtl/coherence_bus_ctrl.sv
// Dual-core snooping-coherence responder: arbitrates dcache coherence requests, snoops the peer, fronts a single-port RAM.
// Optional macro CC_FWD_EN: requester is served from a 2-word buffer filled by a dirty snoop write-back.
module coherence_bus_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int RR_INIT = 0
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic [1:0]            cctrans,
   input  logic [1:0]            ccwrite,
   input  logic [1:0]            dREN,
   input  logic [1:0]            dWEN,
   input  logic [2*ADDR_W-1:0]   daddr,
   input  logic [2*DATA_W-1:0]   dstore,
   output logic [1:0]            ccwait,
   output logic [1:0]            ccinv,
   output logic [2*ADDR_W-1:0]   ccsnoopaddr,
   output logic [1:0]            dwait,
   output logic [2*DATA_W-1:0]   dload,
   output logic                  ram_ren,
   output logic                  ram_wen,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic [DATA_W-1:0]     ram_store,
   input  logic [DATA_W-1:0]     ram_load,
   input  logic                  ram_wait
);

   typedef enum logic [2:0] {IDLE, SNOOP, SWB, GRANT, WB} state_t;

   state_t              r_state, w_state_next;
   logic                r_req, w_req_next;
   logic [ADDR_W-1:0]   r_addr, w_addr_next;
   logic                r_inv, w_inv_next;
   logic                r_ren, w_ren_next;
   logic                r_rr, w_rr_next;
   logic                r_wb, w_wb_next;
   logic                r_cnt, w_cnt_next;

   logic                w_snpe;
   logic [1:0]          w_wb_req, w_cc_req;
   logic                w_wb_pick, w_cc_pick;
   logic                w_word_done;
   logic [ADDR_W-1:0]   w_daddr      [2];
   logic [DATA_W-1:0]   w_dstore     [2];
   logic [ADDR_W-1:0]   w_snoop_addr [2];
   logic [DATA_W-1:0]   w_dload      [2];

`ifdef CC_FWD_EN
   logic                r_dirty;
   logic [DATA_W-1:0]   r_fwd_buf [2];
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_core
         assign w_daddr[gi]                         = daddr[gi*ADDR_W +: ADDR_W];
         assign w_dstore[gi]                        = dstore[gi*DATA_W +: DATA_W];
         assign ccsnoopaddr[gi*ADDR_W +: ADDR_W]    = w_snoop_addr[gi];
         assign dload[gi*DATA_W +: DATA_W]          = w_dload[gi];
         assign w_wb_req[gi]                        = dWEN[gi] & ~cctrans[gi];
         assign w_cc_req[gi]                        = cctrans[gi] & (dREN[gi] | ccwrite[gi]);
      end
   endgenerate

   assign w_snpe    = ~r_req;
   assign w_wb_pick = (&w_wb_req) ? r_rr : w_wb_req[1];
   assign w_cc_pick = (&w_cc_req) ? r_rr : w_cc_req[1];

   always_comb begin
      w_state_next    = r_state;
      w_req_next      = r_req;
      w_addr_next     = r_addr;
      w_inv_next      = r_inv;
      w_ren_next      = r_ren;
      w_rr_next       = r_rr;
      w_wb_next       = r_wb;
      w_cnt_next      = r_cnt;
      w_word_done     = 1'b0;
      ccwait          = 2'b00;
      ccinv           = 2'b00;
      dwait           = 2'b11;
      w_snoop_addr[0] = '0;
      w_snoop_addr[1] = '0;
      w_dload[0]      = '0;
      w_dload[1]      = '0;
      ram_ren         = 1'b0;
      ram_wen         = 1'b0;
      ram_addr        = '0;
      ram_store       = '0;

      case (r_state)
         IDLE: begin
            // plain write-backs win over coherence requests
            if (|w_wb_req) begin
               w_wb_next    = w_wb_pick;
               w_state_next = WB;
            end else if (|w_cc_req) begin
               w_req_next   = w_cc_pick;
               w_addr_next  = w_daddr[w_cc_pick];
               w_inv_next   = ccwrite[w_cc_pick];
               w_ren_next   = dREN[w_cc_pick];
               w_state_next = SNOOP;
            end
         end

         SNOOP: begin
            ccwait[w_snpe]       = 1'b1;
            ccinv[w_snpe]        = r_inv;
            w_snoop_addr[w_snpe] = r_addr;
            if (dWEN[w_snpe] && !cctrans[w_snpe]) begin
               ram_wen         = 1'b1;
               ram_addr        = w_daddr[w_snpe];
               ram_store       = w_dstore[w_snpe];
               dwait[w_snpe]   = ram_wait;
            end
            if (cctrans[w_snpe]) begin
               w_state_next = ccwrite[w_snpe] ? SWB : GRANT;
            end
         end

         SWB: begin
            w_snoop_addr[w_snpe] = r_addr;
            if (dWEN[w_snpe]) begin
               ram_wen       = 1'b1;
               ram_addr      = w_daddr[w_snpe];
               ram_store     = w_dstore[w_snpe];
               dwait[w_snpe] = ram_wait;
               w_word_done   = ~ram_wait;
            end
            if (w_word_done && r_cnt) begin
               w_state_next = GRANT;
            end
         end

         GRANT: begin
            ccinv[r_req] = 1'b1;
            if (!r_ren) begin
               w_state_next = IDLE;
               w_rr_next    = w_snpe;
            end else begin
`ifdef CC_FWD_EN
               if (r_dirty) begin
                  w_dload[r_req] = r_fwd_buf[w_daddr[r_req][2]];
                  if (dREN[r_req]) begin
                     dwait[r_req] = 1'b0;
                     w_word_done  = 1'b1;
                  end
               end else
`endif
               begin
                  w_dload[r_req] = ram_load;
                  if (dREN[r_req]) begin
                     ram_ren      = 1'b1;
                     ram_addr     = w_daddr[r_req];
                     dwait[r_req] = ram_wait;
                     w_word_done  = ~ram_wait;
                  end
               end
               if (w_word_done && r_cnt) begin
                  w_state_next = IDLE;
                  w_rr_next    = w_snpe;
               end
            end
         end

         WB: begin
            if (dWEN[r_wb]) begin
               ram_wen     = 1'b1;
               ram_addr    = w_daddr[r_wb];
               ram_store   = w_dstore[r_wb];
               dwait[r_wb] = ram_wait;
               w_word_done = ~ram_wait;
               if (w_word_done && r_cnt) begin
                  w_state_next = IDLE;
               end
            end else begin
               w_state_next = IDLE;
            end
         end

         default: w_state_next = IDLE;
      endcase

      // word counter restarts on every state entry
      if (w_state_next != r_state) begin
         w_cnt_next = 1'b0;
      end else if (w_word_done) begin
         w_cnt_next = ~r_cnt;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= IDLE;
         r_req   <= 1'b0;
         r_addr  <= '0;
         r_inv   <= 1'b0;
         r_ren   <= 1'b0;
         r_rr    <= (RR_INIT != 0);
         r_wb    <= 1'b0;
         r_cnt   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_req   <= w_req_next;
         r_addr  <= w_addr_next;
         r_inv   <= w_inv_next;
         r_ren   <= w_ren_next;
         r_rr    <= w_rr_next;
         r_wb    <= w_wb_next;
         r_cnt   <= w_cnt_next;
      end
   end

`ifdef CC_FWD_EN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_dirty <= 1'b0;
      end else if (r_state == SNOOP && cctrans[w_snpe]) begin
         r_dirty <= ccwrite[w_snpe];
      end
   end

   always_ff @(posedge CLK) begin
      if (r_state == SWB && w_word_done) begin
         r_fwd_buf[w_daddr[w_snpe][2]] <= w_dstore[w_snpe];
      end
   end
`endif

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Self-checking bench for coherence_bus_ctrl: scripted core behaviour, RAM model with programmable wait, read/write scoreboards.
`timescale 1ns/1ps
module tb_coherence_bus_ctrl;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            CLK  = 1'b0;
   logic            nRST = 1'b1;
   logic [1:0]      cctrans, ccwrite, dREN, dWEN;
   logic [2*AW-1:0] daddr;
   logic [2*DW-1:0] dstore;
   logic [1:0]      ccwait, ccinv, dwait;
   logic [2*AW-1:0] ccsnoopaddr;
   logic [2*DW-1:0] dload;
   logic            ram_ren, ram_wen, ram_wait;
   logic [AW-1:0]   ram_addr;
   logic [DW-1:0]   ram_store, ram_load;

   int errors = 0;
   int checks = 0;
   int lat = 0;
   int wcnt = 0;
   int both_seen = 0;
   bit fwd = 1'b0;

   logic [DW-1:0]    mem   [256];
   bit               mem_v [256];
   logic [AW+DW-1:0] wr_seen[$];
   logic [AW+DW-1:0] exp_wr[$];
   logic [DW-1:0]    exp_rd[$];
   logic [DW-1:0]    model [logic [AW-1:0]];

   always #5 CLK = ~CLK;

   coherence_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RR_INIT(0)) dut (
      .CLK(CLK), .nRST(nRST), .cctrans(cctrans), .ccwrite(ccwrite), .dREN(dREN), .dWEN(dWEN),
      .daddr(daddr), .dstore(dstore), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
      .dwait(dwait), .dload(dload), .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
      .ram_store(ram_store), .ram_load(ram_load), .ram_wait(ram_wait));

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return 32'hA5A5_0000 ^ a;
   endfunction

   // RAM model: each access waits 'lat' cycles, then completes
   assign ram_wait = (ram_ren | ram_wen) && (wcnt < lat);
   assign ram_load = ram_ren ? (mem_v[ram_addr[9:2]] ? mem[ram_addr[9:2]] : pat(ram_addr)) : '0;

   always @(posedge CLK) begin
      if ((ram_ren | ram_wen) && ram_wait) wcnt <= wcnt + 1;
      else                                 wcnt <= 0;
      if (ram_wen && !ram_wait) begin
         mem[ram_addr[9:2]]   <= ram_store;
         mem_v[ram_addr[9:2]] <= 1'b1;
         wr_seen.push_back({ram_addr, ram_store});
      end
      if (ram_ren && ram_wen) both_seen <= both_seen + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      cctrans = '0; ccwrite = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
   endtask

   task automatic drive(input int c, input logic tr, input logic wr, input logic ren,
                        input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cctrans[c] = tr; ccwrite[c] = wr; dREN[c] = ren; dWEN[c] = wen;
      daddr[c*AW +: AW] = a; dstore[c*DW +: DW] = d;
   endtask

   // two-word block read by core c; expected data comes from the bench's own memory model
   task automatic serve_read(input int c, input logic [AW-1:0] base, input bit from_buf);
      logic [AW-1:0] a;
      logic [DW-1:0] e;
      int waits;
      bit done;
      for (int k = 0; k < 2; k++) begin
         a = base + 32'(4*k);
         exp_rd.push_back(model.exists(a) ? model[a] : pat(a));
         dREN[c] = 1'b1;
         daddr[c*AW +: AW] = a;
         waits = 0;
         done = 1'b0;
         for (int n = 0; n < 20 && !done; n++) begin
            #1;
            if (dwait[c] === 1'b0) begin
               done = 1'b1;
               e = exp_rd.pop_front();
               checks++; if (dload[c*DW +: DW] !== e) begin errors++; $display("FAIL rd_data core%0d @%h: got %h expected %h", c, a, dload[c*DW +: DW], e); end
               checks++; if (waits != (from_buf ? 0 : lat)) begin errors++; $display("FAIL rd_waits core%0d @%h: got %0d expected %0d", c, a, waits, (from_buf ? 0 : lat)); end
               checks++;
               if (from_buf) begin
                  if (ram_ren !== 1'b0) begin errors++; $display("FAIL rd_fwd_ram_ren core%0d: got %b expected 0", c, ram_ren); end
               end else if (ram_ren !== 1'b1 || ram_addr !== a) begin
                  errors++; $display("FAIL rd_ram_access core%0d: got ren=%b addr=%h expected ren=1 addr=%h", c, ram_ren, ram_addr, a);
               end
               $display("rd core%0d addr %h data %h waits %0d", c, a, dload[c*DW +: DW], waits);
            end else begin
               waits++;
            end
            tick();
         end
         if (!done) begin
            checks++; errors++;
            $display("FAIL rd_timeout core%0d @%h: got no completion expected completion", c, a);
            void'(exp_rd.pop_front());
         end
      end
      dREN[c] = 1'b0;
   endtask

   // two-word write by core c; the other core must be held off throughout
   task automatic serve_write(input int c, input logic [AW-1:0] base, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      logic [AW-1:0]    a;
      logic [DW-1:0]    d;
      logic [AW+DW-1:0] obs, ex;
      bit done;
      for (int k = 0; k < 2; k++) begin
         a = base + 32'(4*k);
         d = (k == 0) ? d0 : d1;
         exp_wr.push_back({a, d});
         model[a] = d;
         dWEN[c] = 1'b1;
         daddr[c*AW +: AW] = a;
         dstore[c*DW +: DW] = d;
         done = 1'b0;
         for (int n = 0; n < 20 && !done; n++) begin
            #1;
            checks++; if (dwait[1-c] !== 1'b1) begin errors++; $display("FAIL wr_other_dwait core%0d: got %b expected 1", 1-c, dwait[1-c]); end
            if (dwait[c] === 1'b0) done = 1'b1;
            tick();
         end
         ex = exp_wr.pop_front();
         checks++;
         if (!done) begin
            errors++; $display("FAIL wr_timeout core%0d @%h: got no completion expected completion", c, a);
         end else if (wr_seen.size() == 0) begin
            errors++; $display("FAIL wr_missing core%0d: got no RAM write expected %h", c, ex);
         end else begin
            obs = wr_seen.pop_front();
            if (obs !== ex) begin errors++; $display("FAIL wr_data core%0d: got %h expected %h", c, obs, ex); end
         end
         $display("wr core%0d addr %h data %h", c, a, d);
      end
      dWEN[c] = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      #1 nRST = 1'b0;
      #2;
      checks++; if (ccwait !== 2'b00)    begin errors++; $display("FAIL reset_ccwait: got %b expected 00", ccwait); end
      checks++; if (ccinv !== 2'b00)     begin errors++; $display("FAIL reset_ccinv: got %b expected 00", ccinv); end
      checks++; if (ccsnoopaddr !== '0)  begin errors++; $display("FAIL reset_snoopaddr: got %h expected 0", ccsnoopaddr); end
      checks++; if (dwait !== 2'b11)     begin errors++; $display("FAIL reset_dwait: got %b expected 11", dwait); end
      checks++; if (dload !== '0)        begin errors++; $display("FAIL reset_dload: got %h expected 0", dload); end
      checks++; if ({ram_ren, ram_wen} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {ram_ren, ram_wen}); end
      checks++; if (ram_addr !== '0 || ram_store !== '0) begin errors++; $display("FAIL reset_ram_bus: got %h/%h expected 0/0", ram_addr, ram_store); end
      tick();
      nRST = 1'b1;
      tick();
   endtask

   task automatic test_clean_read();
      lat = 2;
      drive(0, 1, 0, 1, 0, 32'h40, '0);
      #1;
      checks++; if (ccwait !== 2'b00 || dwait !== 2'b11) begin errors++; $display("FAIL clean_idle_quiet: got ccwait=%b dwait=%b expected 00/11", ccwait, dwait); end
      tick(); #1;
      checks++; if (ccwait !== 2'b10) begin errors++; $display("FAIL clean_snoop_ccwait: got %b expected 10", ccwait); end
      checks++; if (ccsnoopaddr[AW +: AW] !== 32'h40) begin errors++; $display("FAIL clean_snoop_addr: got %h expected 00000040", ccsnoopaddr[AW +: AW]); end
      checks++; if (ccinv !== 2'b00 || dwait[0] !== 1'b1) begin errors++; $display("FAIL clean_snoop_inv: got ccinv=%b dwait0=%b expected 00/1", ccinv, dwait[0]); end
      drive(1, 1, 0, 0, 0, '0, '0);
      tick();
      drive(1, 0, 0, 0, 0, '0, '0);
      cctrans[0] = 1'b0;
      #1;
      checks++; if (ccinv !== 2'b01 || ccwait !== 2'b00) begin errors++; $display("FAIL clean_grant: got ccinv=%b ccwait=%b expected 01/00", ccinv, ccwait); end
      serve_read(0, 32'h40, 1'b0);
      #1;
      checks++; if (dwait !== 2'b11 || ccinv !== 2'b00) begin errors++; $display("FAIL clean_end_idle: got dwait=%b ccinv=%b expected 11/00", dwait, ccinv); end
      clear_inputs();
      tick();
   endtask

   task automatic test_upgrade();
      lat = 1;
      drive(1, 1, 1, 0, 0, 32'h80, '0);
      #1; tick(); #1;
      checks++; if (ccwait !== 2'b01 || ccinv !== 2'b01) begin errors++; $display("FAIL upg_snoop: got ccwait=%b ccinv=%b expected 01/01", ccwait, ccinv); end
      checks++; if (ccsnoopaddr[0 +: AW] !== 32'h80) begin errors++; $display("FAIL upg_snoop_addr: got %h expected 00000080", ccsnoopaddr[0 +: AW]); end
      drive(0, 1, 0, 0, 0, '0, '0);
      tick();
      drive(0, 0, 0, 0, 0, '0, '0);
      #1;
      checks++; if (ccinv !== 2'b10 || ccwait !== 2'b00) begin errors++; $display("FAIL upg_grant: got ccinv=%b ccwait=%b expected 10/00", ccinv, ccwait); end
      checks++; if ({ram_ren, ram_wen} !== 2'b00) begin errors++; $display("FAIL upg_no_ram: got %b expected 00", {ram_ren, ram_wen}); end
      drive(1, 0, 0, 0, 0, '0, '0);
      tick(); #1;
      checks++; if (ccinv !== 2'b00 || dwait !== 2'b11) begin errors++; $display("FAIL upg_one_cycle: got ccinv=%b dwait=%b expected 00/11", ccinv, dwait); end
      $display("upgrade core1 addr 00000080 granted");
      clear_inputs();
      tick();
   endtask

   task automatic test_dirty_snoop();
      lat = 1;
      drive(0, 1, 0, 1, 0, 32'h100, '0);
      #1; tick(); #1;
      checks++; if (ccwait !== 2'b10 || ccinv !== 2'b00) begin errors++; $display("FAIL dirty_snoop: got ccwait=%b ccinv=%b expected 10/00", ccwait, ccinv); end
      drive(1, 1, 1, 0, 0, 32'h100, '0);
      tick();
      drive(1, 0, 0, 0, 0, 32'h100, '0);
      #1;
      checks++; if (ccwait !== 2'b00 || dwait !== 2'b11) begin errors++; $display("FAIL dirty_swb_entry: got ccwait=%b dwait=%b expected 00/11", ccwait, dwait); end
      serve_write(1, 32'h100, 32'hDEAD_BEEF, 32'hCAFE_F00D);
      cctrans[0] = 1'b0;
      #1;
      checks++; if (ccinv !== 2'b01) begin errors++; $display("FAIL dirty_grant: got ccinv=%b expected 01", ccinv); end
      serve_read(0, 32'h100, fwd);
      #1;
      checks++; if (dwait !== 2'b11) begin errors++; $display("FAIL dirty_end_idle: got dwait=%b expected 11", dwait); end
      clear_inputs();
      tick();
   endtask

   task automatic test_tie_rr();
      lat = 0;
      nRST = 1'b0;
      #2 nRST = 1'b1;
      tick();
      drive(0, 1, 0, 1, 0, 32'h200, '0);
      drive(1, 1, 0, 1, 0, 32'h300, '0);
      #1; tick(); #1;
      checks++; if (ccwait !== 2'b10) begin errors++; $display("FAIL tie1_winner: got ccwait=%b expected 10", ccwait); end
      checks++; if (ccsnoopaddr[AW +: AW] !== 32'h200) begin errors++; $display("FAIL tie1_addr: got %h expected 00000200", ccsnoopaddr[AW +: AW]); end
      tick();
      cctrans[0] = 1'b0;
      #1;
      checks++; if (ccinv !== 2'b01) begin errors++; $display("FAIL tie1_grant: got ccinv=%b expected 01", ccinv); end
      serve_read(0, 32'h200, 1'b0);
      clear_inputs();
      tick();
      drive(0, 1, 0, 1, 0, 32'h200, '0);
      drive(1, 1, 0, 1, 0, 32'h300, '0);
      #1; tick(); #1;
      checks++; if (ccwait !== 2'b01) begin errors++; $display("FAIL tie2_winner: got ccwait=%b expected 01", ccwait); end
      checks++; if (ccsnoopaddr[0 +: AW] !== 32'h300) begin errors++; $display("FAIL tie2_addr: got %h expected 00000300", ccsnoopaddr[0 +: AW]); end
      tick();
      cctrans[1] = 1'b0;
      cctrans[0] = 1'b0;
      dREN[0] = 1'b0;
      #1;
      checks++; if (ccinv !== 2'b10) begin errors++; $display("FAIL tie2_grant: got ccinv=%b expected 10", ccinv); end
      serve_read(1, 32'h300, 1'b0);
      clear_inputs();
      tick();
   endtask

   task automatic test_wb_priority();
      lat = 1;
      drive(1, 1, 0, 1, 0, 32'h180, '0);
      serve_write(0, 32'h180, 32'h1111_1111, 32'h2222_2222);
      #1;
      checks++; if (ccwait !== 2'b00 || dwait !== 2'b11) begin errors++; $display("FAIL wb_back_idle: got ccwait=%b dwait=%b expected 00/11", ccwait, dwait); end
      tick(); #1;
      checks++; if (ccwait !== 2'b01 || ccsnoopaddr[0 +: AW] !== 32'h180) begin errors++; $display("FAIL wb_then_snoop: got ccwait=%b addr=%h expected 01/00000180", ccwait, ccsnoopaddr[0 +: AW]); end
      drive(0, 1, 0, 0, 0, '0, '0);
      tick();
      drive(0, 0, 0, 0, 0, '0, '0);
      cctrans[1] = 1'b0;
      #1;
      checks++; if (ccinv !== 2'b10) begin errors++; $display("FAIL wb_grant: got ccinv=%b expected 10", ccinv); end
      serve_read(1, 32'h180, 1'b0);
      clear_inputs();
      tick();
   endtask

   task automatic test_reset_mid_grant();
      lat = 3;
      drive(0, 1, 0, 1, 0, 32'h48, '0);
      #1; tick();
      drive(1, 1, 0, 0, 0, '0, '0);
      tick();
      drive(1, 0, 0, 0, 0, '0, '0);
      cctrans[0] = 1'b0;
      #1;
      checks++; if (ccinv !== 2'b01 || ram_ren !== 1'b1) begin errors++; $display("FAIL rst_pre_grant: got ccinv=%b ren=%b expected 01/1", ccinv, ram_ren); end
      nRST = 1'b0;
      #1;
      checks++; if (ccwait !== 2'b00 || ccinv !== 2'b00 || dwait !== 2'b11) begin errors++; $display("FAIL rst_mid_cc: got ccwait=%b ccinv=%b dwait=%b expected 00/00/11", ccwait, ccinv, dwait); end
      checks++; if (ram_ren !== 1'b0 || ram_addr !== '0 || dload !== '0 || ccsnoopaddr !== '0) begin errors++; $display("FAIL rst_mid_bus: got ren=%b addr=%h dload=%h expected 0/0/0", ram_ren, ram_addr, dload); end
      clear_inputs();
      tick();
      nRST = 1'b1;
      tick();
      drive(0, 1, 0, 1, 0, 32'h48, '0);
      #1; tick(); #1;
      checks++; if (ccwait !== 2'b10) begin errors++; $display("FAIL rst_fresh_snoop: got ccwait=%b expected 10", ccwait); end
      drive(1, 1, 0, 0, 0, '0, '0);
      tick();
      drive(1, 0, 0, 0, 0, '0, '0);
      cctrans[0] = 1'b0;
      #1;
      checks++; if (ccinv !== 2'b01) begin errors++; $display("FAIL rst_fresh_grant: got ccinv=%b expected 01", ccinv); end
      serve_read(0, 32'h48, 1'b0);
      #1;
      checks++; if (dwait !== 2'b11) begin errors++; $display("FAIL rst_fresh_end: got dwait=%b expected 11", dwait); end
      clear_inputs();
      tick();
   endtask

   task automatic test_final();
      checks++; if (both_seen != 0) begin errors++; $display("FAIL ram_exclusive: got %0d dual-strobe cycles expected 0", both_seen); end
      checks++; if (wr_seen.size() != 0) begin errors++; $display("FAIL ram_extra_writes: got %0d expected 0", wr_seen.size()); end
   endtask

   initial begin
`ifdef CC_FWD_EN
      fwd = 1'b1;
`endif
      clear_inputs();
      test_reset();
      test_clean_read();
      test_upgrade();
      test_dirty_snoop();
      test_tie_rr();
      test_wb_priority();
      test_reset_mid_grant();
      test_final();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
